jk_universal_reg: RTL and testbench
===================================

JK_UNIVERSAL_REG -- requirements
Module: jk_universal_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 1..64).
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  update enable; 0 = all state holds.
REQ-006 mode  input  3  operation select, encoded per REQ-012.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 j  input  WIDTH  per-bit J inputs.
REQ-009 k  input  WIDTH  per-bit K inputs.
REQ-010 sin  input  1  serial input for the shift modes.
REQ-011 q  output  WIDTH  register state; qbar  output  WIDTH  bitwise complement of q; sout  output  1  registered shifted-out bit.

Function
REQ-012 Mode encoding: 000 HOLD, 001 LOAD, 010 JK, 011 TOGGLE, 100 SHL, 101 SHR, 110 ROTL, 111 CLEAR.
REQ-013 Priority at each rising edge: rst, then en=0 (hold everything), then mode.
REQ-014 HOLD: q holds.
REQ-015 LOAD: q <= d, with a result identical to JK mode driven with j=d and k=~d.
REQ-016 JK: per-bit update.
- j=0,k=0: hold.
- j=1,k=0: set.
- j=0,k=1: clear.
- j=1,k=1: toggle.
REQ-017 TOGGLE: q <= ~q.
REQ-018 SHL: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
REQ-019 SHR: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
REQ-020 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= q[WIDTH-1].
REQ-021 CLEAR: q <= all zeros, independent of RST_VAL.
REQ-022 sout updates only in SHL, SHR and ROTL; it holds in all other modes and whenever en=0.
REQ-023 WIDTH=1 boundary cases:
- SHL and SHR: q <= sin.
- ROTL: q unchanged, sout <= q.
REQ-024 qbar is derived from the register, not separately stored, and equals ~q at all times, including during and after reset.
REQ-025 Latency: every operation is visible on q, qbar and sout one clock after the edge that samples it; there is no combinational path from any input to q or sout.
REQ-026 Inputs (d, j, k, sin, mode) are ignored in any cycle where rst=1 or en=0.

Reset
REQ-027 While rst=1 at a rising edge: q <= RST_VAL, qbar <= ~RST_VAL, sout <= 0, regardless of en, mode or data.
REQ-028 rst asserted in the same cycle as any operation, including a shift mid-stream, cancels that operation completely; sout does not capture the shifted-out bit.
REQ-029 Before the first rst edge, outputs are unspecified; the bench applies rst before checking.

Verification (WIDTH=8, RST_VAL=0 unless stated)
REQ-030 Reset priority: rst=1, en=1, mode=LOAD, d=0xFF for one edge -> q=0x00, qbar=0xFF, sout=0.
REQ-031 Load and enable:
- LOAD d=0xA5 -> q=0xA5.
- Then en=0, mode=LOAD, d=0x00 for 3 edges -> q stays 0xA5.
REQ-032 JK and TOGGLE:
- From q=0xA5, JK with j=0xF0, k=0x3C -> q=0xD1, qbar=0x2E.
- Next edge, TOGGLE -> q=0x2E.
REQ-033 Shifts and rotate:
- From q=0x81, SHL sin=1 -> q=0x03, sout=1.
- Then SHR sin=0 -> q=0x01, sout=1.
- Reload 0x81, ROTL -> q=0x03, sout=1.
- Then HOLD -> sout stays 1.
REQ-034 Reset mid-shift: RST_VAL=0x5A; from q=0x81, assert rst on the same edge as SHL -> q=0x5A, sout=0.
- Then CLEAR -> q=0x00, qbar=0xFF.
REQ-035 WIDTH=1 instance: LOAD d=1 -> q=1.
- ROTL -> q=1, sout=1.
- SHR sin=0 -> q=0, sout=1.
- JK j=1, k=1 -> q=1.

Source files
------------

// File: rtl/jk_universal_reg.sv
// Universal register with a JK flip-flop per bit: hold, load, JK, toggle, shift, rotate and clear.
// Includes a registered serial output and a complement output derived from the register.
module jk_universal_reg #(
  parameter int unsigned         WIDTH   = 8,
  parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout
);

  typedef enum logic [2:0] {
    ModeHold   = 3'b000,
    ModeLoad   = 3'b001,
    ModeJk     = 3'b010,
    ModeToggle = 3'b011,
    ModeShl    = 3'b100,
    ModeShr    = 3'b101,
    ModeRotl   = 3'b110,
    ModeClear  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [WIDTH-1:0] shl_val, shr_val, rotl_val, jk_val;

  // A one-bit register has no interior bits to shift, so the shift paths collapse to sin / q.
  if (WIDTH == 1) begin : g_w1
    assign shl_val  = sin;
    assign shr_val  = sin;
    assign rotl_val = q_q;
  end else begin : g_wn
    assign shl_val  = {q_q[WIDTH-2:0], sin};
    assign shr_val  = {sin, q_q[WIDTH-1:1]};
    assign rotl_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
  end

  // Per-bit JK characteristic equation: q+ = j&~q | ~k&q.
  assign jk_val = (j & ~q_q) | (~k & q_q);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (en) begin
      unique case (mode_e'(mode))
        ModeHold:   q_d = q_q;
        ModeLoad:   q_d = d;
        ModeJk:     q_d = jk_val;
        ModeToggle: q_d = ~q_q;
        ModeShl: begin
          q_d    = shl_val;
          sout_d = q_q[WIDTH-1];
        end
        ModeShr: begin
          q_d    = shr_val;
          sout_d = q_q[0];
        end
        ModeRotl: begin
          q_d    = rotl_val;
          sout_d = q_q[WIDTH-1];
        end
        ModeClear:  q_d = '0;
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_VAL;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;
  assign sout = sout_q;

endmodule

// File: tb/tb_jk_universal_reg.sv
// Scoreboard bench for jk_universal_reg: three instances (8-bit, 8-bit with RST_VAL=0x5A, 1-bit)
// share one stimulus stream and are checked against a behavioural model every cycle.
module tb_jk_universal_reg;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, JK = 3'b010, TOGGLE = 3'b011,
                         SHL = 3'b100, SHR = 3'b101, ROTL = 3'b110, CLEAR = 3'b111;

  logic       clk = 1'b0;
  logic       rst, en, sin;
  logic [2:0] mode;
  logic [7:0] d, j, k;

  logic [7:0] q8, qb8, q5, qb5;
  logic       so8, so5;
  logic [0:0] q1, qb1;
  logic       so1;

  always #5 clk = ~clk;

  jk_universal_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .j(j), .k(k), .sin(sin),
    .q(q8), .qbar(qb8), .sout(so8)
  );

  jk_universal_reg #(.WIDTH(8), .RST_VAL(8'h5A)) u_w8_5a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .j(j), .k(k), .sin(sin),
    .q(q5), .qbar(qb5), .sout(so5)
  );

  jk_universal_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[0:0]), .j(j[0:0]), .k(k[0:0]),
    .sin(sin), .q(q1), .qbar(qb1), .sout(so1)
  );

  typedef struct {
    int          step;
    logic [63:0] q8, q5, q1;
    logic        s8, s5, s1;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          step_no  = 0;

  // Reference model state (one per instance).
  logic [63:0] m_q8, m_q5, m_q1;
  logic        m_s8, m_s5, m_s1;

  function automatic void model_step(input int unsigned w, input logic [63:0] rv,
                                     inout logic [63:0] mq, inout logic ms);
    logic [63:0] mask;
    logic [63:0] nq;
    logic        msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = mq[w-1];
    nq   = mq;
    if (rst) begin
      mq = rv & mask;
      ms = 1'b0;
      return;
    end
    if (!en) return;
    case (mode)
      LOAD:   nq = {56'd0, d} & mask;
      JK: begin
        for (int i = 0; i < int'(w); i++) begin
          case ({j[i], k[i]})
            2'b10:   nq[i] = 1'b1;
            2'b01:   nq[i] = 1'b0;
            2'b11:   nq[i] = ~mq[i];
            default: nq[i] = mq[i];
          endcase
        end
      end
      TOGGLE: nq = ~mq & mask;
      SHL: begin
        nq = ((mq << 1) | {63'd0, sin}) & mask;
        ms = msb;
      end
      SHR: begin
        nq = (mq >> 1) | ({63'd0, sin} << (w - 1));
        ms = mq[0];
      end
      ROTL: begin
        nq = ((mq << 1) | {63'd0, msb}) & mask;
        ms = msb;
      end
      CLEAR:  nq = 64'd0;
      default: nq = mq;
    endcase
    mq = nq;
  endfunction

  task automatic check(input string name, input int stp, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, stp, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; on the sampling edge update the model and push the expectation.
  task automatic apply(input logic r, input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic [7:0] jj, input logic [7:0] kk, input logic s);
    exp_t x;
    rst = r; en = e; mode = m; d = dd; j = jj; k = kk; sin = s;
    @(posedge clk);
    model_step(8, 64'h00, m_q8, m_s8);
    model_step(8, 64'h5A, m_q5, m_s5);
    model_step(1, 64'h0, m_q1, m_s1);
    step_no++;
    x.step = step_no;
    x.q8 = m_q8; x.q5 = m_q5; x.q1 = m_q1;
    x.s8 = m_s8; x.s5 = m_s5; x.s1 = m_s1;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: outputs are stable one time unit after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("w8_q",     x.step, {56'd0, q8},  x.q8);
        check("w8_qbar",  x.step, {56'd0, qb8}, ~x.q8 & 64'hFF);
        check("w8_sout",  x.step, {63'd0, so8}, {63'd0, x.s8});
        check("w5a_q",    x.step, {56'd0, q5},  x.q5);
        check("w5a_qbar", x.step, {56'd0, qb5}, ~x.q5 & 64'hFF);
        check("w5a_sout", x.step, {63'd0, so5}, {63'd0, x.s5});
        check("w1_q",     x.step, {63'd0, q1},  x.q1);
        check("w1_qbar",  x.step, {63'd0, qb1}, ~x.q1 & 64'h1);
        check("w1_sout",  x.step, {63'd0, so1}, {63'd0, x.s1});
      end
    end
  end

  initial begin
    m_q8 = '0; m_q5 = '0; m_q1 = '0;
    m_s8 = 1'b0; m_s5 = 1'b0; m_s1 = 1'b0;
    rst = 1'b1; en = 1'b0; mode = HOLD; d = '0; j = '0; k = '0; sin = 1'b0;
    @(negedge clk);

    // Reset beats a simultaneous load.
    apply(1, 1, LOAD, 8'hFF, 8'h00, 8'h00, 0);
    // Load, then en=0 holds for three edges.
    apply(0, 1, LOAD, 8'hA5, 8'h00, 8'h00, 0);
    repeat (3) apply(0, 0, LOAD, 8'h00, 8'hFF, 8'hFF, 1);
    // JK then toggle.
    apply(0, 1, JK, 8'h00, 8'hF0, 8'h3C, 0);
    apply(0, 1, TOGGLE, 8'h00, 8'h00, 8'h00, 0);
    // Shifts and rotate from 0x81.
    apply(0, 1, LOAD, 8'h81, 8'h00, 8'h00, 0);
    apply(0, 1, SHL, 8'h00, 8'h00, 8'h00, 1);
    apply(0, 1, SHR, 8'h00, 8'h00, 8'h00, 0);
    apply(0, 1, LOAD, 8'h81, 8'h00, 8'h00, 0);
    apply(0, 1, ROTL, 8'h00, 8'h00, 8'h00, 0);
    apply(0, 1, HOLD, 8'h00, 8'h00, 8'h00, 0);
    // Reset on the same edge as a shift, then clear.
    apply(0, 1, LOAD, 8'h81, 8'h00, 8'h00, 0);
    apply(1, 1, SHL, 8'h00, 8'h00, 8'h00, 1);
    apply(0, 1, CLEAR, 8'h00, 8'h00, 8'h00, 0);
    // One-bit boundary sequence.
    apply(0, 1, LOAD, 8'h01, 8'h00, 8'h00, 0);
    apply(0, 1, ROTL, 8'h00, 8'h00, 8'h00, 0);
    apply(0, 1, SHR, 8'h00, 8'h00, 8'h00, 0);
    apply(0, 1, JK, 8'h00, 8'h01, 8'h01, 0);

    // Randomized traffic with occasional reset and disabled cycles.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom));
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
